// File: rtl/shift_div_seq.sv
// rtl/shift_div_seq.sv - power-of-two divider sequencing 4-bit coarse and 1-bit fine shift steps.
// Optional remainder output and mask register: define SHIFT_DIV_REMAINDER_EN.
module shift_div_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [3:0]       shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
`ifdef SHIFT_DIV_REMAINDER_EN
  output logic [WIDTH-1:0] remainder,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COARSE = 2'd1,
    FINE   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             accept;

  assign accept = in_valid && (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          data_d = dividend;
          cnt_d  = shamt;
          if (shamt >= 4'd4)      state_d = COARSE;
          else if (shamt != 4'd0) state_d = FINE;
          else                    state_d = DONE;
        end
      end
      COARSE: begin
        data_d = data_q >> 4;
        cnt_d  = cnt_q - 4'd4;
        if (cnt_d >= 4'd4)      state_d = COARSE;
        else if (cnt_d != 4'd0) state_d = FINE;
        else                    state_d = DONE;
      end
      FINE: begin
        data_d = data_q >> 1;
        cnt_d  = cnt_q - 4'd1;
        if (cnt_d == 4'd0) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SHIFT_DIV_REMAINDER_EN
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] low_mask;

  // Low s bits set; shift amounts beyond WIDTH keep the whole dividend.
  always_comb begin
    low_mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      low_mask[i] = (i < int'(shamt));
    end
  end

  always_comb begin
    mask_d = mask_q;
    if (accept) mask_d = dividend & low_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mask_q <= '0;
    else        mask_q <= mask_d;
  end

  assign remainder = mask_q;
`endif

  // Outputs decode only flopped state, so nothing combinational from inputs.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == COARSE) || (state_q == FINE);
  assign quotient  = data_q;

endmodule

// File: tb/tb_shift_div_seq.sv
// tb/tb_shift_div_seq.sv - table-driven scoreboard bench for shift_div_seq.
// Remainder checks are active when SHIFT_DIV_REMAINDER_EN is defined.
module tb_shift_div_seq;

  typedef struct {
    logic [15:0] dvd;
    logic [3:0]  s;
    logic [15:0] q;
    logic [15:0] r;
    int          n;
  } vec_t;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    int          n;
    int          acc;
  } sb_item_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] dividend = '0;
  logic [3:0]  shamt = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] quotient;
  logic        busy;
`ifdef SHIFT_DIV_REMAINDER_EN
  logic [15:0] remainder;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int last_hand = -100;
  logic prev_ov = 1'b0;
  sb_item_t sb[$];
  vec_t vecs[13];

  shift_div_seq #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .shamt     (shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
`ifdef SHIFT_DIV_REMAINDER_EN
    .remainder (remainder),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: latency and busy-length at out_valid rise, result at handoff.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_ready) busy_cnt = 0;
      else if (busy) busy_cnt++;
      if (out_valid && !prev_ov) begin
        if (sb.size() == 0) chk("unexpected_out_valid", 1, 0);
        else begin
          chk("latency", cyc - sb[0].acc, sb[0].n);
          chk("busy_cycles", busy_cnt, sb[0].n);
        end
      end
      if (out_valid && out_ready && sb.size() > 0) begin
        sb_item_t it;
        it = sb.pop_front();
        chk("quotient", quotient, it.q);
`ifdef SHIFT_DIV_REMAINDER_EN
        chk("remainder", remainder, it.r);
`endif
        last_hand = cyc + 1;
      end
      prev_ov = out_valid;
    end else begin
      prev_ov = 1'b0;
    end
  end

  task automatic do_req(input logic [15:0] d, input logic [3:0] s, input logic [15:0] eq,
                        input logic [15:0] er, input int n, output int acc);
    bit got;
    sb_item_t it;
    got = 1'b0;
    acc = -1;
    in_valid = 1'b1;
    dividend = d;
    shamt = s;
    for (int w = 0; w < 200; w++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    acc = cyc + 1;
    it.q = eq;
    it.r = er;
    it.n = n;
    it.acc = acc;
    sb.push_back(it);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    dividend = $urandom;
    shamt = 4'($urandom);
  endtask

  task automatic drain();
    for (int w = 0; w < 500 && sb.size() > 0; w++) @(negedge clk);
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    int acc, prev_acc, prev_n, acc2;
    vecs[0] = '{16'hAAAA, 4'd4,  16'h0AAA, 16'h000A, 1};
    vecs[1] = '{16'h1234, 4'd0,  16'h1234, 16'h0000, 0};
    vecs[2] = '{16'hF0F0, 4'd15, 16'h0001, 16'h70F0, 6};
    for (int i = 3; i < 13; i++) begin
      vecs[i].dvd = 16'($urandom);
      vecs[i].s   = 4'($urandom_range(0, 15));
      vecs[i].q   = vecs[i].dvd >> vecs[i].s;
      vecs[i].r   = vecs[i].dvd & ((16'd1 << vecs[i].s) - 16'd1);
      vecs[i].n   = int'(vecs[i].s) / 4 + int'(vecs[i].s) % 4;
    end

    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_quotient", quotient, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    out_ready = 1'b1;
    prev_acc = 0;
    prev_n = 0;
    for (int i = 0; i < 13; i++) begin
      do_req(vecs[i].dvd, vecs[i].s, vecs[i].q, vecs[i].r, vecs[i].n, acc);
      if (i > 0) chk("spacing", acc - prev_acc, prev_n + 2);
      prev_acc = acc;
      prev_n = vecs[i].n;
    end
    drain();

    // Result held while consumer stalls; second request waits for IDLE.
    @(posedge clk);
    #2;
    out_ready = 1'b0;
    do_req(16'h0F0F, 4'd7, 16'h001E, 16'h000F, 4, acc);
    acc2 = -1;
    fork
      begin
        bit seen;
        seen = 1'b0;
        for (int w = 0; w < 50; w++) begin
          @(negedge clk);
          if (out_valid) begin
            seen = 1'b1;
            break;
          end
        end
        chk("hold_out_valid_seen", seen, 1);
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("hold_quotient", quotient, 16'h001E);
          chk("hold_out_valid", out_valid, 1);
`ifdef SHIFT_DIV_REMAINDER_EN
          chk("hold_remainder", remainder, 16'h000F);
`endif
        end
        @(posedge clk);
        #2;
        out_ready = 1'b1;
      end
      begin
        @(posedge clk);
        #2;
        do_req(16'h00FF, 4'd2, 16'h003F, 16'h0003, 2, acc2);
      end
    join
    chk("held_req_accept_edge", acc2, last_hand + 1);
    drain();

    // Asynchronous reset mid-COARSE discards the operation.
    @(posedge clk);
    #2;
    do_req(16'hFFFF, 4'd9, 16'h007F, 16'h01FF, 3, acc);
    #1;
    chk("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_in_ready", in_ready, 1);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_quotient", quotient, 0);
`ifdef SHIFT_DIV_REMAINDER_EN
    chk("async_rst_remainder", remainder, 0);
`endif
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    do_req(16'h8000, 4'd3, 16'h1000, 16'h0000, 3, acc);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
